// File: rtl/mvu_stream_pkg.sv
// Shared constants and width helpers for the MVU weight streaming path.
package mvu_stream_pkg;

    localparam int STREAMER_CREDITS = 4;

    function automatic int byte_align(input int w);
        return (w + 7) / 8 * 8;
    endfunction

    // Width of one weight_word_t = logic [PE-1:0][SIMD-1:0][WEIGHT_WIDTH-1:0], PE major.
    function automatic int weight_word_bits(input int pe, input int simd, input int wbits);
        return pe * simd * wbits;
    endfunction

endpackage

// File: rtl/weight_stream_skid_fifo.sv
// Two-entry first-word-fall-through register FIFO; slot0 is always the head.
module weight_stream_skid_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             empty,
    output logic             full,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] slot0;
    logic [WIDTH-1:0] slot1;
    logic [1:0]       count;

    // The head only moves on pop or when filling an empty FIFO, so it is stable while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 2'd0;
            slot0 <= '0;
            slot1 <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) slot0 <= din;
                    else               slot1 <= din;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    slot0 <= slot1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        slot0 <= din;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign empty = (count == 2'd0);
    assign full  = (count == 2'd2);
    assign head  = slot0;

endmodule

// File: rtl/mvu_weight_streamer.sv
// Streams an on-chip NF*SF weight matrix continuously over AXI-Stream, frame after frame.
// Optional runtime weight writes are enabled by defining WEIGHT_STREAMER_CFG_WRITE_EN.
module mvu_weight_streamer
    import mvu_stream_pkg::*;
#(
    parameter int    MW           = 25,
    parameter int    MH           = 4,
    parameter int    SIMD         = 1,
    parameter int    PE           = 1,
    parameter int    WEIGHT_WIDTH = 4,
    parameter string INIT_FILE    = "",
    parameter string RAM_STYLE    = "auto",
    localparam int   NF           = MH / PE,
    localparam int   SF           = MW / SIMD,
    localparam int   DEPTH        = NF * SF,
    localparam int   WW           = weight_word_bits(PE, SIMD, WEIGHT_WIDTH),
    localparam int   WW_BA        = byte_align(WW),
    localparam int   AW           = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    output logic [WW_BA-1:0] m_axis_weights_tdata,
    output logic             m_axis_weights_tvalid,
    input  logic             m_axis_weights_tready,
    output logic             frame_done
`ifdef WEIGHT_STREAMER_CFG_WRITE_EN
    ,
    input  logic             cfg_we,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [WW-1:0]    cfg_wdata
`endif
);

    typedef logic [PE-1:0][SIMD-1:0][WEIGHT_WIDTH-1:0] weight_word_t;

    localparam int            CW        = $clog2(STREAMER_CREDITS + 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    (* ram_style = RAM_STYLE *) weight_word_t mem [DEPTH];

    logic [CW-1:0] credits;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] issue_addr;
    logic [AW-1:0] beat_addr;
    logic          issue_valid;
    logic          rd_valid;
    weight_word_t  rd_data;
    logic [WW-1:0] fifo_head;
    logic          fifo_empty;
    logic          fifo_full;
    logic          issue;
    logic          beat;
    logic          fifo_ready;
    logic          rd_adv;
    logic          push;

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    end

    // Elastic pipeline: each stage holds its word until the next one frees up. With four
    // credits spread over two stages and two FIFO slots, credits>0 always implies a bubble.
    assign beat       = m_axis_weights_tvalid && m_axis_weights_tready;
    assign issue      = (credits != '0);
    assign fifo_ready = !fifo_full || beat;
    assign rd_adv     = !rd_valid || fifo_ready;
    assign push       = rd_valid && fifo_ready;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            credits     <= CW'(STREAMER_CREDITS);
            rd_addr     <= '0;
            issue_addr  <= '0;
            issue_valid <= 1'b0;
            rd_valid    <= 1'b0;
        end else begin
            if (issue && !beat)
                credits <= credits - 1'b1;
            else if (!issue && beat)
                credits <= credits + 1'b1;

            if (issue) begin
                issue_addr <= rd_addr;
                rd_addr    <= (rd_addr == LAST_ADDR) ? '0 : rd_addr + 1'b1;
            end

            if (issue)
                issue_valid <= 1'b1;
            else if (rd_adv)
                issue_valid <= 1'b0;

            if (rd_adv)
                rd_valid <= issue_valid;
        end
    end

    // Memory port is deliberately outside reset so weights survive it.
    always_ff @(posedge ap_clk) begin
`ifdef WEIGHT_STREAMER_CFG_WRITE_EN
        if (cfg_we && (int'(cfg_addr) < DEPTH))
            mem[cfg_addr] <= cfg_wdata;
`endif
        if (rd_adv && issue_valid)
            rd_data <= mem[issue_addr];
    end

    weight_stream_skid_fifo #(
        .WIDTH (WW)
    ) u_skid (
        .clk   (ap_clk),
        .rst_n (ap_rst_n),
        .push  (push),
        .din   (rd_data),
        .pop   (beat),
        .empty (fifo_empty),
        .full  (fifo_full),
        .head  (fifo_head)
    );

    // Beats are counted separately from reads so frame_done tracks accepted words only.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            beat_addr  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= beat && (beat_addr == LAST_ADDR);
            if (beat)
                beat_addr <= (beat_addr == LAST_ADDR) ? '0 : beat_addr + 1'b1;
        end
    end

    assign m_axis_weights_tvalid = !fifo_empty;
    assign m_axis_weights_tdata  = WW_BA'(fifo_head);

endmodule

// File: tb/tb_mvu_weight_streamer.sv
// Directed bench for mvu_weight_streamer (100-word matrix plus a DEPTH=1 instance).
module tb_mvu_weight_streamer;

    logic       ap_clk = 1'b0;
    logic       ap_rst_n;
    logic       tready;
    logic [7:0] tdata;
    logic       tvalid;
    logic       frame_done;
    logic       tready1;
    logic [7:0] tdata1;
    logic       tvalid1;
    logic       frame_done1;
`ifdef WEIGHT_STREAMER_CFG_WRITE_EN
    logic       cfg_we;
    logic [6:0] cfg_addr;
    logic [3:0] cfg_wdata;
`endif

    int         n_checks;
    int         n_fail;
    int         beat_idx;
    logic       fd_exp;
    logic [3:0] model [100];
    logic [7:0] exp8;

    always #5 ap_clk = ~ap_clk;

    mvu_weight_streamer #(
        .MW(25), .MH(4), .SIMD(1), .PE(1), .WEIGHT_WIDTH(4)
    ) dut (
        .ap_clk                (ap_clk),
        .ap_rst_n              (ap_rst_n),
        .m_axis_weights_tdata  (tdata),
        .m_axis_weights_tvalid (tvalid),
        .m_axis_weights_tready (tready),
        .frame_done            (frame_done)
`ifdef WEIGHT_STREAMER_CFG_WRITE_EN
        ,
        .cfg_we                (cfg_we),
        .cfg_addr              (cfg_addr),
        .cfg_wdata             (cfg_wdata)
`endif
    );

    mvu_weight_streamer #(
        .MW(1), .MH(1), .SIMD(1), .PE(1), .WEIGHT_WIDTH(4)
    ) dut1 (
        .ap_clk                (ap_clk),
        .ap_rst_n              (ap_rst_n),
        .m_axis_weights_tdata  (tdata1),
        .m_axis_weights_tvalid (tvalid1),
        .m_axis_weights_tready (tready1),
        .frame_done            (frame_done1)
`ifdef WEIGHT_STREAMER_CFG_WRITE_EN
        ,
        .cfg_we                (1'b0),
        .cfg_addr              (1'b0),
        .cfg_wdata             (4'h0)
`endif
    );

    // Held data must not change while the sink stalls a valid word.
    assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
                     (tvalid && !tready) |=> (tvalid && $stable(tdata)))
        n_checks++;
    else begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL sva_hold: tdata/tvalid changed while stalled, tdata=%h", tdata);
    end

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic restart();
        ap_rst_n = 1'b0;
        step();
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        step();
        step();
        step();
        beat_idx = 0;
        fd_exp   = 1'b0;
    endtask

    task automatic test_reset();
        ap_rst_n = 1'b0;
        tready   = 1'b1;
        step();
        n_checks++;
        if (tvalid !== 1'b0) begin
            n_fail++; $display("[TB] FAIL reset_tvalid: got %b want 0", tvalid);
        end
        n_checks++;
        if (frame_done !== 1'b0) begin
            n_fail++; $display("[TB] FAIL reset_frame_done: got %b want 0", frame_done);
        end
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        for (int e = 1; e <= 2; e++) begin
            step();
            n_checks++;
            if (tvalid !== 1'b0) begin
                n_fail++; $display("[TB] FAIL latency_early edge %0d: tvalid %b want 0", e, tvalid);
            end
        end
        step();
        n_checks++;
        if (tvalid !== 1'b1) begin
            n_fail++; $display("[TB] FAIL latency_edge3: tvalid %b want 1", tvalid);
        end
        exp8 = {4'b0000, model[0]};
        n_checks++;
        if (tdata !== exp8) begin
            n_fail++; $display("[TB] FAIL first_word: tdata %h want %h", tdata, exp8);
        end
        beat_idx = 0;
        fd_exp   = 1'b0;
    endtask

    task automatic test_stream();
        for (int c = 0; c < 201; c++) begin
            exp8 = {4'b0000, model[beat_idx % 100]};
            n_checks++;
            if (tvalid !== 1'b1 || tdata !== exp8) begin
                n_fail++;
                $display("[TB] FAIL stream beat %0d: tvalid %b tdata %h want 1/%h", beat_idx, tvalid, tdata, exp8);
            end
            n_checks++;
            if (frame_done !== fd_exp) begin
                n_fail++; $display("[TB] FAIL stream_frame_done beat %0d: got %b want %b", beat_idx, frame_done, fd_exp);
            end
            fd_exp = (beat_idx % 100 == 99);
            beat_idx++;
            step();
        end
    endtask

    task automatic test_backpressure();
        tready = 1'b1;
        restart();
        for (int c = 0; c < 10; c++) begin
            beat_idx++;
            step();
        end
        tready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            exp8 = {4'b0000, model[10]};
            n_checks++;
            if (tvalid !== 1'b1 || tdata !== exp8 || frame_done !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL stall cycle %0d: tvalid %b tdata %h fd %b want 1/%h/0", c, tvalid, tdata, frame_done, exp8);
            end
        end
        n_checks++;
        if (dut.rd_addr !== 7'd14) begin
            n_fail++; $display("[TB] FAIL stall_reads: rd_addr %0d want 14", dut.rd_addr);
        end
        tready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            exp8 = {4'b0000, model[beat_idx]};
            n_checks++;
            if (tvalid !== 1'b1 || tdata !== exp8) begin
                n_fail++;
                $display("[TB] FAIL resume beat %0d: tvalid %b tdata %h want 1/%h", beat_idx, tvalid, tdata, exp8);
            end
            beat_idx++;
            step();
        end
    endtask

    task automatic test_random();
        logic       stalled;
        logic [7:0] held;
        int         cycles;
        tready = 1'b1;
        restart();
        stalled = 1'b0;
        held    = '0;
        cycles  = 0;
        while (beat_idx < 500 && cycles < 3000) begin
            tready = ($urandom_range(0, 9) < 7);
            if (tvalid === 1'b1) begin
                exp8 = {4'b0000, model[beat_idx % 100]};
                n_checks++;
                if (tdata !== exp8) begin
                    n_fail++; $display("[TB] FAIL random beat %0d: tdata %h want %h", beat_idx, tdata, exp8);
                end
            end
            if (stalled) begin
                n_checks++;
                if (tvalid !== 1'b1 || tdata !== held) begin
                    n_fail++; $display("[TB] FAIL random_hold: tvalid %b tdata %h want 1/%h", tvalid, tdata, held);
                end
            end
            n_checks++;
            if (frame_done !== fd_exp) begin
                n_fail++; $display("[TB] FAIL random_frame_done beat %0d: got %b want %b", beat_idx, frame_done, fd_exp);
            end
            fd_exp  = (tvalid === 1'b1) && tready && (beat_idx % 100 == 99);
            stalled = (tvalid === 1'b1) && !tready;
            held    = tdata;
            if (tvalid === 1'b1 && tready) beat_idx++;
            step();
            cycles++;
        end
        n_checks++;
        if (beat_idx != 500) begin
            n_fail++; $display("[TB] FAIL random_timeout: beats %0d want 500", beat_idx);
        end
        tready = 1'b1;
    endtask

    task automatic test_reset_midframe();
        tready = 1'b1;
        restart();
        while (beat_idx < 37) begin
            beat_idx++;
            step();
        end
        exp8 = {4'b0000, model[37]};
        n_checks++;
        if (tdata !== exp8) begin
            n_fail++; $display("[TB] FAIL midframe_word37: tdata %h want %h", tdata, exp8);
        end
        #2;
        ap_rst_n = 1'b0;
        #1;
        n_checks++;
        if (tvalid !== 1'b0 || frame_done !== 1'b0) begin
            n_fail++; $display("[TB] FAIL async_reset: tvalid %b fd %b want 0/0", tvalid, frame_done);
        end
        step();
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        step();
        step();
        n_checks++;
        if (tvalid !== 1'b0) begin
            n_fail++; $display("[TB] FAIL restart_early: tvalid %b want 0", tvalid);
        end
        step();
        for (int c = 0; c < 3; c++) begin
            exp8 = {4'b0000, model[c]};
            n_checks++;
            if (tvalid !== 1'b1 || tdata !== exp8) begin
                n_fail++; $display("[TB] FAIL restart beat %0d: tvalid %b tdata %h want 1/%h", c, tvalid, tdata, exp8);
            end
            step();
        end
    endtask

    task automatic test_depth_one();
        tready = 1'b1;
        restart();
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (tvalid1 !== 1'b1 || tdata1 !== 8'h09) begin
                n_fail++; $display("[TB] FAIL depth1 cycle %0d: tvalid %b tdata %h want 1/09", c, tvalid1, tdata1);
            end
            n_checks++;
            if (frame_done1 !== (c > 0)) begin
                n_fail++; $display("[TB] FAIL depth1_frame_done cycle %0d: got %b want %b", c, frame_done1, (c > 0));
            end
            n_checks++;
            if (dut1.rd_addr !== 1'b0) begin
                n_fail++; $display("[TB] FAIL depth1_addr cycle %0d: got %b want 0", c, dut1.rd_addr);
            end
            step();
        end
    endtask

`ifdef WEIGHT_STREAMER_CFG_WRITE_EN
    task automatic test_cfg_write();
        tready = 1'b1;
        restart();
        for (int c = 0; c < 110; c++) begin
            cfg_we = 1'b0;
            if (beat_idx == 4) begin
                cfg_we    = 1'b1;
                cfg_addr  = 7'd5;
                cfg_wdata = 4'hA;
            end else if (beat_idx == 6) begin
                cfg_we    = 1'b1;
                cfg_addr  = 7'd120;
                cfg_wdata = 4'hF;
            end
            if (beat_idx == 100) model[5] = 4'hA;
            exp8 = {4'b0000, model[beat_idx % 100]};
            n_checks++;
            if (tvalid !== 1'b1 || tdata !== exp8) begin
                n_fail++; $display("[TB] FAIL cfg beat %0d: tvalid %b tdata %h want 1/%h", beat_idx, tvalid, tdata, exp8);
            end
            beat_idx++;
            step();
        end
        cfg_we = 1'b0;
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        ap_rst_n = 1'b0;
        tready   = 1'b1;
        tready1  = 1'b1;
`ifdef WEIGHT_STREAMER_CFG_WRITE_EN
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_wdata = '0;
`endif
        for (int i = 0; i < 100; i++) model[i] = 4'((i * 7 + 3) % 16);
        #1;
        for (int i = 0; i < 100; i++) dut.mem[i] = model[i];
        dut1.mem[0] = 4'h9;

        test_reset();
        test_stream();
        test_backpressure();
        test_random();
        test_reset_midframe();
        test_depth_one();
`ifdef WEIGHT_STREAMER_CFG_WRITE_EN
        test_cfg_write();
`endif
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
